// File: rtl/pipeline_frontend_ctrl_pkg.sv
// Shared pipeline definitions: NOP encoding, PC step and the ID/EX control bundle
// used by the front-end controller and the hazard/forwarding logic.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0,
                                             mem_write: 1'b0, rd: 5'd0};

endpackage

// File: rtl/pipeline_frontend_ctrl_if.sv
// Hazard/branch control inputs and pipeline-register outputs of the front-end controller.
interface pipeline_frontend_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             pc_write_i;
    logic             if_id_write_i;
    logic             bubble_i;
    logic             branch_taken_i;
    logic [XLEN-1:0]  branch_target_i;
    logic [31:0]      instr_i;
    logic             id_reg_write_i;
    logic             id_mem_read_i;
    logic             id_mem_write_i;
    logic [4:0]       id_rd_i;

    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  if_id_pc_o;
    logic [31:0]      if_id_instr_o;
    logic             if_id_valid_o;
    logic             id_ex_reg_write_o;
    logic             id_ex_mem_read_o;
    logic             id_ex_mem_write_o;
    logic [4:0]       id_ex_rd_o;
    logic             id_ex_valid_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             protocol_err_o;
    logic             stall_timeout_o;

    modport master (
        output pc_write_i, if_id_write_i, bubble_i, branch_taken_i, branch_target_i,
               instr_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_rd_i,
        input  pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, id_ex_reg_write_o,
               id_ex_mem_read_o, id_ex_mem_write_o, id_ex_rd_o, id_ex_valid_o,
               stall_cnt_o, flush_cnt_o, protocol_err_o, stall_timeout_o
    );

    modport slave (
        input  pc_write_i, if_id_write_i, bubble_i, branch_taken_i, branch_target_i,
               instr_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_rd_i,
        output pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, id_ex_reg_write_o,
               id_ex_mem_read_o, id_ex_mem_write_o, id_ex_rd_o, id_ex_valid_o,
               stall_cnt_o, flush_cnt_o, protocol_err_o, stall_timeout_o
    );

endinterface

// File: rtl/pipeline_frontend_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: assign the default first so every path drives cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_frontend_ctrl.sv
// Front-end pipeline control: PC, IF/ID register, ID/EX control half, stall/flush
// statistics and stall-protocol checking.
module pipeline_frontend_ctrl
    import pipeline_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter int          MAX_STALL = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    pipeline_frontend_ctrl_if.slave bus
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    id_ex_ctrl_t     id_ex_q, id_ex_d;
    logic            id_ex_valid_q, id_ex_valid_d;
    logic            perr_q, perr_d;
    logic            tout_q, tout_d;

    logic [2:0]       stall_vec;
    logic             stall_ok;
    logic             stall_cycle;
    logic             proto_bad;
    logic [RUN_W-1:0] run_cnt;

    always_comb begin
        stall_vec   = {bus.pc_write_i, bus.if_id_write_i, bus.bubble_i};
        stall_ok    = (stall_vec == 3'b001);
        stall_cycle = stall_ok && !bus.branch_taken_i;
        // A taken branch overrides whatever the hazard unit requests that cycle.
        proto_bad   = !bus.branch_taken_i && !stall_ok && (stall_vec != 3'b110);

        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        id_ex_d       = ID_EX_BUBBLE;
        id_ex_valid_d = 1'b0;

        if (bus.branch_taken_i) begin
            pc_d = bus.branch_target_i;
        end else if (bus.pc_write_i) begin
            pc_d = pc_q + XLEN'(PC_INC);
        end

        if (bus.branch_taken_i) begin
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (bus.if_id_write_i) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = bus.instr_i;
            if_id_valid_d = 1'b1;
        end

        if (!(bus.branch_taken_i || bus.bubble_i || !if_id_valid_q)) begin
            id_ex_d = '{reg_write: bus.id_reg_write_i, mem_read: bus.id_mem_read_i,
                        mem_write: bus.id_mem_write_i, rd: bus.id_rd_i};
            id_ex_valid_d = 1'b1;
        end

        perr_d = perr_q | proto_bad;
        // Set on the stall that takes the run from MAX_STALL to MAX_STALL+1.
        tout_d = tout_q | (stall_cycle && (run_cnt >= RUN_W'(MAX_STALL)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= XLEN'(RESET_PC);
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            id_ex_q       <= ID_EX_BUBBLE;
            id_ex_valid_q <= 1'b0;
            perr_q        <= 1'b0;
            tout_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            id_ex_q       <= id_ex_d;
            id_ex_valid_q <= id_ex_valid_d;
            perr_q        <= perr_d;
            tout_q        <= tout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_cycle),
        .clr_i (1'b0),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bus.branch_taken_i),
        .clr_i (1'b0),
        .cnt_o (bus.flush_cnt_o)
    );

    sat_counter #(.W(RUN_W)) u_stall_run (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_cycle),
        .clr_i (!stall_cycle),
        .cnt_o (run_cnt)
    );

    assign bus.pc_o              = pc_q;
    assign bus.if_id_pc_o        = if_id_pc_q;
    assign bus.if_id_instr_o     = if_id_instr_q;
    assign bus.if_id_valid_o     = if_id_valid_q;
    assign bus.id_ex_reg_write_o = id_ex_q.reg_write;
    assign bus.id_ex_mem_read_o  = id_ex_q.mem_read;
    assign bus.id_ex_mem_write_o = id_ex_q.mem_write;
    assign bus.id_ex_rd_o        = id_ex_q.rd;
    assign bus.id_ex_valid_o     = id_ex_valid_q;
    assign bus.protocol_err_o    = perr_q;
    assign bus.stall_timeout_o   = tout_q;

endmodule
